// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort stuck transfers with an err pulse.
//
// state     | meaning
// IDLE      | search for a valid requester starting at rr_ptr
// ISSUE     | spi_newd held high until the master reports busy
// WAIT_DONE | frame in flight, waiting for spi_done
// GAP       | inter-frame idle time before the next grant
module spi_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 12,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       spi_newd,
  output logic [DATA_W-1:0]          spi_din,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       xfer_active,
  output logic                       xfer_done,
  output logic                       err
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ID_W:0]    NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ-1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES-1) : '0;

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_req_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]    grant_nxt;
  logic [DATA_W-1:0]  din_nxt;
  logic               newd_nxt, active_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               done_evt;
  logic               to_expire;

  logic [ID_W-1:0]    sel_id;
  logic               sel_found;
  logic [DATA_W-1:0]  sel_data;
  logic [ID_W:0]      cand;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_X) cand = cand - NUM_REQ_X;
      if (!sel_found && req_valid[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[ID_W-1:0];
      end
    end
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_id == ID_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && sel_found) req_ready[sel_id] = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    din_nxt    = spi_din;
    newd_nxt   = spi_newd;
    active_nxt = xfer_active;
    gap_nxt    = gap_cnt;
    done_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt  = ISSUE;
          din_nxt    = sel_data;
          grant_nxt  = sel_id;
          active_nxt = 1'b1;
          newd_nxt   = 1'b1;
        end
      end
      ISSUE, WAIT_DONE: begin
        // A done seen while still in ISSUE completes the frame just like WAIT_DONE.
        if (spi_done || to_expire) begin
          done_evt   = spi_done;
          newd_nxt   = 1'b0;
          active_nxt = 1'b0;
          rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = GAP_LOAD;
          end
        end else if (state == ISSUE && spi_busy) begin
          newd_nxt  = 1'b0;
          state_nxt = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      spi_din     <= '0;
      spi_newd    <= 1'b0;
      xfer_active <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_id    <= grant_nxt;
      spi_din     <= din_nxt;
      spi_newd    <= newd_nxt;
      xfer_active <= active_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

  assign xfer_done = done_evt & ~rst;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES-1);

  logic [TO_W-1:0] to_cnt;

  assign to_expire = (state == ISSUE || state == WAIT_DONE) && (to_cnt == '0) && !spi_done;

  // Reloaded on every state change so ISSUE and WAIT_DONE each get the full budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= to_expire;
      if (state_nxt != state)
        to_cnt <= TO_LOAD;
      else if ((state == ISSUE || state == WAIT_DONE) && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
    end
  end
`else
  assign to_expire = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: directed requests, SPI master model, grant monitor.
module tb_spi_req_arbiter;
  localparam int GAP = 2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic [3:0]  req_ready;
  logic        spi_newd;
  logic [11:0] spi_din;
  logic        spi_busy, spi_done;
  logic [1:0]  grant_id;
  logic        xfer_active, xfer_done, err;

  logic m_busy = 1'b0, m_done = 1'b0, f_busy = 1'b0, f_done = 1'b0;
  bit   model_en = 1'b1;
  bit   b2b = 1'b0;

  assign spi_busy = m_busy | f_busy;
  assign spi_done = m_done | f_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_seen   = 0;

  typedef struct packed {
    logic [3:0]  onehot;
    logic [1:0]  id;
    logic [11:0] data;
  } exp_t;
  exp_t exp_q[$];

  spi_req_arbiter #(
    .NUM_REQ(4), .DATA_W(12), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .spi_newd(spi_newd), .spi_din(spi_din),
    .spi_busy(spi_busy), .spi_done(spi_done), .grant_id(grant_id),
    .xfer_active(xfer_active), .xfer_done(xfer_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [11:0] data);
    exp_t e;
    e.onehot = 4'(1 << id);
    e.id     = 2'(id);
    e.data   = data;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Holds mask valid until n acceptances; with drop, each accepted requester withdraws.
  task automatic run_grants(input logic [3:0] mask, input int n, input bit drop, output int first_lat);
    int got;
    int cycles;
    logic [3:0] r;
    got = 0;
    cycles = 0;
    first_lat = 0;
    @(posedge clk); #1;
    req_valid = mask;
    while (got < n && cycles < 400) begin
      @(negedge clk);
      cycles++;
      r = req_ready;
      @(posedge clk); #1;
      if (r != 4'b0) begin
        got++;
        if (first_lat == 0) first_lat = cycles;
        if (drop) req_valid = req_valid & ~r;
      end
    end
    req_valid = '0;
    check("batch_grants", 32'(got), 32'(n));
  endtask

  task automatic wait_done();
    int cycles;
    bit seen;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (xfer_done) seen = 1'b1;
    end
    check("xfer_done_seen", 32'(seen), 32'd1);
  endtask

  // SPI master: busy for 3 cycles after newd, then a 1-cycle done.
  initial begin : spi_model
    forever begin
      @(posedge clk); #1;
      if (model_en && spi_newd && !m_busy) begin
        m_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        m_busy = 1'b0;
        m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int cyc;
    int last_done;
    bit have_done;
    cyc = 0;
    last_done = 0;
    have_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_done = 1'b0;
      end else begin
        if (xfer_done) begin
          last_done = cyc;
          have_done = 1'b1;
        end
        if (req_ready != 4'b0) begin
          n_seen++;
          if (have_done) begin
            if (b2b) check("gap_exact", 32'(cyc - last_done), 32'(GAP + 1));
            else     check("gap_min", 32'((cyc - last_done) >= GAP + 1), 32'd1);
          end
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'(req_ready), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ready_onehot", 32'(req_ready), 32'(e.onehot));
            @(negedge clk);
            cyc++;
            check("grant_din", 32'(spi_din), 32'(e.data));
            check("grant_id", 32'(grant_id), 32'(e.id));
            check("newd_latency", 32'(spi_newd), 32'd1);
            check("xfer_active_on", 32'(xfer_active), 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : main
    int lat;
    int err_cnt;
    int done_cnt;
    int first_err;
    int waitc;
    rst = 1'b1;
    req_valid = '0;
    req_data = {12'h004, 12'h003, 12'h002, 12'h001};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_newd", 32'(spi_newd), 32'd0);
    check("rst_din", 32'(spi_din), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(xfer_active), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_newd", 32'(spi_newd), 32'd0);
    check("idle_xfer_done", 32'(xfer_done), 32'd0);

    // busy/done in IDLE are ignored
    @(posedge clk); #1;
    f_busy = 1'b1;
    f_done = 1'b1;
    @(negedge clk);
    check("idle_done_ignored", 32'(xfer_done), 32'd0);
    @(posedge clk); #1;
    f_busy = 1'b0;
    f_done = 1'b0;
    @(negedge clk);
    check("idle_busy_ignored", 32'(spi_newd), 32'd0);
    check("idle_active", 32'(xfer_active), 32'd0);

    // Single request from requester 2
    req_data[2*12 +: 12] = 12'hA5C;
    push(2, 12'hA5C);
    run_grants(4'b0100, 1, 1'b1, lat);
    check("ready_latency", 32'(lat), 32'd1);
    @(negedge clk);
    check("newd_high", 32'(spi_newd), 32'd1);
    @(negedge clk);
    check("newd_drop_on_busy", 32'(spi_newd), 32'd0);
    check("active_in_flight", 32'(xfer_active), 32'd1);
    wait_done();
    @(negedge clk);
    check("active_after_done", 32'(xfer_active), 32'd0);
    check("din_held", 32'(spi_din), 32'hA5C);

    // Search resumes at 3: 3 before 0
    push(3, 12'h004);
    push(0, 12'h001);
    run_grants(4'b1001, 2, 1'b1, lat);
    wait_done();

    // Wrap priority: move rr_ptr to 3, then 0 before 1
    push(2, 12'hA5C);
    run_grants(4'b0100, 1, 1'b1, lat);
    wait_done();
    push(0, 12'h001);
    push(1, 12'h002);
    run_grants(4'b0011, 2, 1'b1, lat);
    wait_done();

    // Reset during WAIT_DONE; the late done must be ignored
    push(2, 12'hA5C);
    run_grants(4'b0100, 1, 1'b1, lat);
    @(posedge clk); #1;
    @(negedge clk);
    check("in_wait_done_newd", 32'(spi_newd), 32'd0);
    check("in_wait_done_active", 32'(xfer_active), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_newd", 32'(spi_newd), 32'd0);
    check("midrst_active", 32'(xfer_active), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("late_done_ignored", 32'(xfer_done), 32'd0);

    // Fairness with all four continuously valid (rr_ptr back at 0)
    req_data = {12'h004, 12'h003, 12'h002, 12'h001};
    b2b = 1'b1;
    push(0, 12'h001);
    push(1, 12'h002);
    push(2, 12'h003);
    push(3, 12'h004);
    push(0, 12'h001);
    run_grants(4'b1111, 5, 1'b0, lat);
    wait_done();

    // Lone requester granted back-to-back
    push(1, 12'h002);
    push(1, 12'h002);
    run_grants(4'b0010, 2, 1'b0, lat);
    wait_done();
    b2b = 1'b0;

    // Request withdrawn during GAP is dropped
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (8) @(negedge clk);
    check("dropped_request_grant_id", 32'(grant_id), 32'd1);
    check("dropped_request_count", 32'(n_seen), 32'(n_pushed));

    // Master never responds
    model_en = 1'b0;
    push(0, 12'h001);
    run_grants(4'b0001, 1, 1'b1, lat);
    err_cnt = 0;
    done_cnt = 0;
    first_err = 0;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err) begin
        err_cnt++;
        if (first_err == 0) first_err = k;
      end
      if (xfer_done) done_cnt++;
    end
    check("timeout_err_timing", 32'(first_err), 32'(TMO + 1));
    check("timeout_err_pulses", 32'(err_cnt), 32'd1);
    check("timeout_no_xfer_done", 32'(done_cnt), 32'd0);
    check("timeout_active_cleared", 32'(xfer_active), 32'd0);
    check("timeout_newd_cleared", 32'(spi_newd), 32'd0);
    model_en = 1'b1;
    push(1, 12'h002);
    push(0, 12'h001);
    run_grants(4'b0011, 2, 1'b1, lat);
    wait_done();
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err) err_cnt++;
      if (xfer_done) done_cnt++;
    end
    check("no_timeout_err", 32'(err_cnt), 32'd0);
    check("no_timeout_done", 32'(done_cnt), 32'd0);
    check("stuck_in_issue_newd", 32'(spi_newd), 32'd1);
    check("stuck_in_issue_active", 32'(xfer_active), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_en = 1'b1;
    push(3, 12'h004);
    run_grants(4'b1000, 1, 1'b1, lat);
    wait_done();
`endif

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("total_grants", 32'(n_seen), 32'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Round-robin scheduler that shares one 12-bit SPI master among NUM_REQ requesters.
- Accepts one word per valid/ready handshake and drives the master's newd/din strobe.
- Tracks the transfer through the master's busy/done status, then enforces an inter-frame gap before the next grant.
- Sits between client blocks and the SPI master; all signals are in the clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 12, SPI word width.
- GAP_CYCLES, 2, idle clk cycles after each transfer completes, before the next grant (0 allowed).
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester word pending.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot, 1-cycle acceptance pulse.
- spi_newd  out  1  start strobe to the SPI master.
- spi_din  out  DATA_W  word to the SPI master.
- spi_busy  in  1  high while the master is mid-frame (chip select active).
- spi_done  in  1  1-cycle pulse when the master frame ends.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- xfer_active  out  1  high from the grant until spi_done.
- xfer_done  out  1  1-cycle pulse, coincident with leaving WAIT_DONE on success.
- err  out  1  1-cycle timeout pulse (optional feature).

Behaviour:
Reset values:
- state=IDLE, rr_ptr=0, grant_id=0.
- spi_newd=0, spi_din=0, req_ready=0, xfer_active=0, xfer_done=0, err=0, gap and timeout counters=0.

FSM states: IDLE, ISSUE, WAIT_DONE, GAP.

IDLE:
- Select the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
- If one is found, in the same cycle: req_ready[i]=1 (combinational, this cycle only).
- At the clock edge: spi_din<=req_data[i], grant_id<=i, xfer_active<=1, state<=ISSUE.
- If none is found, remain in IDLE; req_ready stays all-zero.

ISSUE:
- spi_newd=1 (registered).
- On spi_busy=1: spi_newd<=0, state<=WAIT_DONE.
- If spi_done=1 is seen while in ISSUE, treat the frame as complete, exactly as in WAIT_DONE.

WAIT_DONE:
- spi_newd=0.
- On spi_done=1: xfer_done pulse, xfer_active<=0, rr_ptr<=(grant_id+1) mod NUM_REQ.
- Then load the gap counter and go to GAP, or go directly to IDLE if GAP_CYCLES=0.

GAP:
- Count GAP_CYCLES cycles, then go to IDLE. No grants are made while in GAP.

Stability and latency:
- spi_din is held constant from the grant until the next grant.
- Minimum latency is 1 cycle from req_valid to req_ready (when IDLE), and 1 cycle from the grant to spi_newd.
- req_valid deasserting after acceptance has no effect.
- req_valid deasserting before acceptance drops that request (no ready pulse).

Boundary conditions:
- All requesters valid continuously: grants rotate 0,1,2,3,0... and there is no starvation.
- Requester i is the only valid one: it is granted back-to-back, separated by GAP_CYCLES+1 cycles after xfer_done.
- spi_busy or spi_done while in IDLE or GAP is ignored.
- rst mid-transfer returns the FSM to IDLE within one cycle, with spi_newd=0 and rr_ptr=0.
  - The master frame already in flight is not aborted.
  - Its late spi_done is ignored because the FSM is in IDLE.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - A counter runs while in ISSUE or WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without spi_done: err pulses for 1 cycle, spi_newd<=0, xfer_active<=0, and no xfer_done is issued.
  - rr_ptr advances past grant_id, and the FSM enters GAP (or IDLE if GAP_CYCLES=0).
  - The counter clears on every state entry.
- Undefined: err is tied to 0, no counter logic exists, and the FSM waits indefinitely for spi_done.

Test Plan:
- Reset check: assert rst 3 cycles -> all outputs 0, state IDLE; spi_done pulse in IDLE -> no xfer_done.
- Single request: req_valid[2]=1, data 0xA5C -> req_ready[2] pulses once, grant_id=2, spi_din=0xA5C, spi_newd high until busy, xfer_done on spi_done; next grant search starts at 3.
- Round-robin fairness: all four valid with data 0x001..0x004, model returns busy/done -> spi_din sequence 0x001,0x002,0x003,0x004,0x001; at least GAP_CYCLES=2 idle cycles between xfer_done and the next req_ready.
- Wrap priority: rr_ptr=3, req_valid=4'b0011 -> requester 0 granted before 1.
- Reset mid-transfer: rst during WAIT_DONE -> next cycle IDLE with spi_newd=0; a later spi_done produces no xfer_done; a new request is granted normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16): spi_busy never asserted -> err pulse exactly 16 cycles after ISSUE entry, no xfer_done, next requester granted; macro undefined -> err stays 0 and the FSM stays in ISSUE.
